// File: rtl/score_bcd_if.sv
// Request/result bundle between the score source and the BCD converter.
// The master drives requests; the slave (converter) returns the status and the held BCD digits.
interface score_bcd_if #(
  parameter int BIN_W = 10
);
  logic [BIN_W-1:0] score;
  logic             score_valid;
  logic             busy;
  logic             done;
  logic [3:0]       bcd_ones;
  logic [3:0]       bcd_tens;
  logic [3:0]       bcd_hundreds;
  logic             saturated;

  modport master (
    output score, score_valid,
    input  busy, done, bcd_ones, bcd_tens, bcd_hundreds, saturated
  );

  modport slave (
    input  score, score_valid,
    output busy, done, bcd_ones, bcd_tens, bcd_hundreds, saturated
  );
endinterface

// File: rtl/score_bcd_converter.sv
// Sequential shift-add-3 converter from the binary score to three BCD digits.
// The digits stay registered between conversions; one request may be queued while busy.
//
//  state | meaning
//  IDLE  | waiting; starts on a fresh request, otherwise on a queued one
//  SHIFT | one add-3 correction and left shift per cycle, BIN_W cycles in total
//  LOAD  | copy the scratch digits to the outputs and pulse done
module score_bcd_converter #(
  parameter int BIN_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  score_bcd_if.slave  bus
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
  localparam logic [BIN_W-1:0] CLAMP = (BIN_W >= 10) ? BIN_W'(999) : '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [BIN_W-1:0] operand_q, operand_d;
  logic [BIN_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [11:0]      scratch_q, scratch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_r_q, sat_r_d;
  logic [11:0]      bcd_q, bcd_d;
  logic             sat_q, sat_d;
  logic             done_q, done_d;

  logic             start;
  logic [BIN_W-1:0] start_val;
  logic [10:0]      start_ext;
  logic             start_sat;
  logic [11:0]      adj;

  // A fresh request wins over the queued one when both are present in IDLE.
  always_comb begin
    start     = (state_q == IDLE) && (bus.score_valid || pend_vld_q);
    start_val = bus.score_valid ? bus.score : pend_q;
    start_ext = 11'(start_val);
    start_sat = start_ext > 11'd999;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST_CNT) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < 3; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    operand_d  = operand_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    sat_r_d    = sat_r_q;
    bcd_d      = bcd_q;
    sat_d      = sat_q;
    done_d     = 1'b0;

    // Requests arriving mid-conversion park here; the latest one overwrites.
    if (bus.score_valid && (state_q != IDLE)) begin
      pend_d     = bus.score;
      pend_vld_d = 1'b1;
    end else if (start) begin
      pend_vld_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          operand_d = start_sat ? CLAMP : start_val;
          sat_r_d   = start_sat;
          scratch_d = '0;
          cnt_d     = '0;
        end
      end
      SHIFT: begin
        scratch_d = (adj << 1) | {11'd0, operand_q[BIN_W-1]};
        operand_d = operand_q << 1;
        cnt_d     = cnt_q + CNT_W'(1);
      end
      LOAD: begin
        bcd_d  = scratch_q;
        sat_d  = sat_r_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      operand_q  <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      sat_r_q    <= 1'b0;
      bcd_q      <= '0;
      sat_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      operand_q  <= operand_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      sat_r_q    <= sat_r_d;
      bcd_q      <= bcd_d;
      sat_q      <= sat_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    bus.busy         = (state_q != IDLE);
    bus.done         = done_q;
    bus.bcd_ones     = bcd_q[3:0];
    bus.bcd_tens     = bcd_q[7:4];
    bus.bcd_hundreds = bcd_q[11:8];
    bus.saturated    = sat_q;
  end

endmodule

// File: tb/tb_score_bcd_converter.sv
// Scoreboard bench for score_bcd_converter: a cycle-level occupancy model predicts which
// scores get converted and when; a monitor checks every done pulse and the held digits.
module tb_score_bcd_converter;

  localparam int BIN_W = 10;

  typedef struct {
    int hund;
    int tens;
    int ones;
    int sat;
    int edge_n;
  } exp_t;

  logic clk;
  logic rst;
  int   edge_cnt;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  int   m_remain;
  bit   m_pend_vld;
  int   m_pend;

  score_bcd_if #(.BIN_W(BIN_W)) ifc ();

  score_bcd_converter #(.BIN_W(BIN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    edge_cnt = 0;
    forever begin
      @(posedge clk);
      edge_cnt++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference conversion: plain decimal arithmetic on the clamped score.
  task automatic start_conv(input int s, input int edge0);
    exp_t e;
    int   v;
    v = (s > 999) ? 999 : s;
    e.hund   = v / 100;
    e.tens   = (v / 10) % 10;
    e.ones   = v % 10;
    e.sat    = (s > 999) ? 1 : 0;
    e.edge_n = edge0 + BIN_W + 1;
    sb_q.push_back(e);
    m_remain = BIN_W + 1;
  endtask

  // Drives one cycle of inputs and advances the occupancy model over the coming edge.
  task automatic drive(input bit v, input int s);
    int up;
    @(negedge clk);
    chk("busy", int'(ifc.busy), (m_remain != 0) ? 1 : 0);
    #2;
    ifc.score_valid = v;
    ifc.score       = BIN_W'(s);
    up = edge_cnt + 1;
    if (m_remain == 0) begin
      if (v) begin
        start_conv(s, up);
        m_pend_vld = 1'b0;
      end else if (m_pend_vld) begin
        start_conv(m_pend, up);
        m_pend_vld = 1'b0;
      end
    end else begin
      if (v) begin
        m_pend     = s;
        m_pend_vld = 1'b1;
      end
      m_remain--;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst             = 1'b1;
    ifc.score_valid = 1'b0;
    m_remain        = 0;
    m_pend_vld      = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk("rst_busy", int'(ifc.busy), 0);
    chk("rst_done", int'(ifc.done), 0);
    chk("rst_sat", int'(ifc.saturated), 0);
    chk("rst_bcd", int'({ifc.bcd_hundreds, ifc.bcd_tens, ifc.bcd_ones}), 0);
    #2;
    rst = 1'b0;
  endtask

  // Monitor: pops on every done, otherwise requires the last loaded digits to be held.
  initial begin
    exp_t e;
    int   l_h, l_t, l_o, l_s;
    l_h = 0; l_t = 0; l_o = 0; l_s = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        l_h = 0; l_t = 0; l_o = 0; l_s = 0;
      end else if (ifc.done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("done_edge", edge_cnt, e.edge_n);
          chk("hundreds", int'(ifc.bcd_hundreds), e.hund);
          chk("tens", int'(ifc.bcd_tens), e.tens);
          chk("ones", int'(ifc.bcd_ones), e.ones);
          chk("saturated", int'(ifc.saturated), e.sat);
          l_h = e.hund; l_t = e.tens; l_o = e.ones; l_s = e.sat;
        end
      end else begin
        chk("held_digits", int'({ifc.bcd_hundreds, ifc.bcd_tens, ifc.bcd_ones}),
            (l_h << 8) | (l_t << 4) | l_o);
        chk("held_sat", int'(ifc.saturated), l_s);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    checks          = 0;
    errors          = 0;
    m_remain        = 0;
    m_pend_vld      = 1'b0;
    m_pend          = 0;
    rst             = 1'b1;
    ifc.score_valid = 1'b0;
    ifc.score       = '0;
    repeat (3) @(posedge clk);
    do_reset();

    drive(1'b1, 0);
    idle(14);
    drive(1'b1, 255);
    idle(14);
    drive(1'b1, 999);
    idle(14);
    drive(1'b1, 1023);
    idle(14);
    drive(1'b1, 7);
    idle(14);

    // Queued requests: 456 is overwritten by 789 before it can start.
    drive(1'b1, 123);
    idle(2);
    drive(1'b1, 456);
    idle(2);
    drive(1'b1, 789);
    idle(30);

    // Reset mid-conversion aborts the conversion and drops the queued request.
    drive(1'b1, 500);
    idle(2);
    drive(1'b1, 300);
    do_reset();
    idle(30);

    drive(1'b1, 1000);
    idle(14);
    idle(50);

    for (int i = 0; i < 20; i++) begin
      drive(1'b1, int'($urandom_range(0, 1023)));
      idle(12 + int'($urandom_range(0, 4)));
    end

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) == 0, int'($urandom_range(0, 1023)));
    end

    n = 0;
    while ((sb_q.size() != 0 || m_remain != 0 || m_pend_vld) && n < 200) begin
      drive(1'b0, 0);
      n++;
    end
    idle(3);
    chk("drain", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
